// File: rtl/systolic_tile_sequencer.sv
// Tile sequencer: walks each tile through LOAD/FEED/DRAIN for a run-time tile count; job = num_tiles*(L+F+D) busy cycles.
// All outputs registered or decoded from state; no backpressure, abort cancels the job on the next edge.
module systolic_tile_sequencer #(
  parameter int ARRAY_N      = 128,
  parameter int LOAD_CYCLES  = ARRAY_N,
  parameter int FEED_CYCLES  = ARRAY_N,
  parameter int DRAIN_CYCLES = ARRAY_N,
  parameter int CNT_W        = 9,
  parameter int TILE_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [TILE_W-1:0] num_tiles,
  output logic              busy,
  output logic [1:0]        phase,
  output logic              w_load_en,
  output logic              feed_en,
  output logic              drain_en,
  output logic [CNT_W-1:0]  phase_count,
  output logic [CNT_W-1:0]  tile_count,
  output logic [TILE_W-1:0] tile_idx,
  output logic              tile_done,
  output logic              job_done,
  output logic              end_signal
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FEED  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  logic [1:0]        r_phase;
  logic [1:0]        w_nxt_phase;
  logic [CNT_W-1:0]  r_phase_count;
  logic [CNT_W-1:0]  r_tile_count;
  logic [TILE_W-1:0] r_tile_idx;
  logic [TILE_W-1:0] r_num_tiles;
  logic              r_tile_done;
  logic              r_job_done;
  logic              r_end;
  logic              w_phase_end;
  logic              w_last_tile;
  logic              w_accept;
  logic              w_tile_end;

  assign w_accept    = (r_phase == S_IDLE) && start && !abort && (num_tiles != '0);
  assign w_last_tile = (r_tile_idx == r_num_tiles - TILE_W'(1));
  assign w_tile_end  = (r_phase == S_DRAIN) && w_phase_end;

  always_comb begin
    w_phase_end = 1'b0;
    case (r_phase)
      S_LOAD:  w_phase_end = (r_phase_count == LOAD_LAST);
      S_FEED:  w_phase_end = (r_phase_count == FEED_LAST);
      S_DRAIN: w_phase_end = (r_phase_count == DRAIN_LAST);
      default: w_phase_end = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= S_IDLE;
    end else begin
      r_phase <= w_nxt_phase;
    end
  end

  always_comb begin
    w_nxt_phase = r_phase;
    if (abort) begin
      w_nxt_phase = S_IDLE;
    end else begin
      case (r_phase)
        S_IDLE:  if (w_accept)    w_nxt_phase = S_LOAD;
        S_LOAD:  if (w_phase_end) w_nxt_phase = S_FEED;
        S_FEED:  if (w_phase_end) w_nxt_phase = S_DRAIN;
        S_DRAIN: if (w_phase_end) w_nxt_phase = w_last_tile ? S_IDLE : S_LOAD;
        default: w_nxt_phase = S_IDLE;
      endcase
    end
  end

  // Counters and completion flags; abort outranks the final-DRAIN completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase_count <= '0;
      r_tile_count  <= '0;
      r_tile_idx    <= '0;
      r_num_tiles   <= '0;
      r_tile_done   <= 1'b0;
      r_job_done    <= 1'b0;
      r_end         <= 1'b0;
    end else begin
      r_tile_done <= 1'b0;
      r_job_done  <= 1'b0;
      if (abort) begin
        r_phase_count <= '0;
        r_tile_count  <= '0;
        r_tile_idx    <= '0;
        r_end         <= 1'b0;
      end else if (w_accept) begin
        r_phase_count <= '0;
        r_tile_count  <= '0;
        r_tile_idx    <= '0;
        r_num_tiles   <= num_tiles;
        r_end         <= 1'b0;
      end else if (r_phase != S_IDLE) begin
        r_phase_count <= w_phase_end ? '0 : r_phase_count + CNT_W'(1);
        if (w_tile_end) begin
          r_tile_count <= '0;
          r_tile_done  <= 1'b1;
          if (w_last_tile) begin
            r_tile_idx <= '0;
            r_job_done <= 1'b1;
            r_end      <= 1'b1;
          end else begin
            r_tile_idx <= r_tile_idx + TILE_W'(1);
          end
        end else begin
          r_tile_count <= r_tile_count + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    busy      = (r_phase != S_IDLE);
    phase     = r_phase;
    w_load_en = (r_phase == S_LOAD);
    feed_en   = (r_phase == S_FEED);
    drain_en  = (r_phase == S_DRAIN);
  end

  assign phase_count = r_phase_count;
  assign tile_count  = r_tile_count;
  assign tile_idx    = r_tile_idx;
  assign tile_done   = r_tile_done;
  assign job_done    = r_job_done;
  assign end_signal  = r_end;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Bench for systolic_tile_sequencer: a default-length unit (u0) and a short-phase unit (u1, L=2 F=3 D=1).
module tb_systolic_tile_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_v [2];
  logic       abort_v [2];
  logic [7:0] nt_v    [2];

  logic       busy_o  [2];
  logic [1:0] phase_o [2];
  logic       len_o   [2];
  logic       fen_o   [2];
  logic       den_o   [2];
  logic [8:0] pc_o    [2];
  logic [8:0] tc_o    [2];
  logic [7:0] ti_o    [2];
  logic       td_o    [2];
  logic       jd_o    [2];
  logic       end_o   [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  systolic_tile_sequencer u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .num_tiles(nt_v[0]),
    .busy(busy_o[0]), .phase(phase_o[0]), .w_load_en(len_o[0]), .feed_en(fen_o[0]),
    .drain_en(den_o[0]), .phase_count(pc_o[0]), .tile_count(tc_o[0]), .tile_idx(ti_o[0]),
    .tile_done(td_o[0]), .job_done(jd_o[0]), .end_signal(end_o[0]));

  systolic_tile_sequencer #(.LOAD_CYCLES(2), .FEED_CYCLES(3), .DRAIN_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .num_tiles(nt_v[1]),
    .busy(busy_o[1]), .phase(phase_o[1]), .w_load_en(len_o[1]), .feed_en(fen_o[1]),
    .drain_en(den_o[1]), .phase_count(pc_o[1]), .tile_count(tc_o[1]), .tile_idx(ti_o[1]),
    .tile_done(td_o[1]), .job_done(jd_o[1]), .end_signal(end_o[1]));

  function automatic int plen(int u, int p);
    if (u == 0) return 128;
    case (p)
      1: return 2;
      2: return 3;
      default: return 1;
    endcase
  endfunction

  // Model: a job is just a cycle offset k into num_tiles*T busy cycles.
  logic m_busy [2];
  int   m_k    [2];
  int   m_nt   [2];
  logic m_td   [2];
  logic m_jd   [2];
  logic m_end  [2];

  always @(posedge clk or posedge rst) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        m_busy[u] <= 1'b0; m_k[u] <= 0; m_nt[u] <= 0;
        m_td[u] <= 1'b0; m_jd[u] <= 1'b0; m_end[u] <= 1'b0;
      end else begin
        m_td[u] <= 1'b0;
        m_jd[u] <= 1'b0;
        if (abort_v[u]) begin
          m_busy[u] <= 1'b0; m_k[u] <= 0; m_end[u] <= 1'b0;
        end else if (!m_busy[u]) begin
          if (start_v[u] && nt_v[u] != 0) begin
            m_busy[u] <= 1'b1; m_k[u] <= 0; m_nt[u] <= int'(nt_v[u]); m_end[u] <= 1'b0;
          end
        end else begin
          int t;
          t = plen(u, 1) + plen(u, 2) + plen(u, 3);
          if (m_k[u] == m_nt[u] * t - 1) begin
            m_busy[u] <= 1'b0; m_k[u] <= 0;
            m_td[u] <= 1'b1; m_jd[u] <= 1'b1; m_end[u] <= 1'b1;
          end else begin
            m_k[u] <= m_k[u] + 1;
            if ((m_k[u] + 1) % t == 0) m_td[u] <= 1'b1;
          end
        end
      end
    end
  end

  function automatic logic [34:0] exp_vec(int u);
    int t, tc, ti, pc;
    logic [1:0] ph;
    t = plen(u, 1) + plen(u, 2) + plen(u, 3);
    tc = 0; ti = 0; pc = 0; ph = 2'd0;
    if (m_busy[u]) begin
      tc = m_k[u] % t;
      ti = m_k[u] / t;
      if (tc < plen(u, 1)) begin
        ph = 2'd1; pc = tc;
      end else if (tc < plen(u, 1) + plen(u, 2)) begin
        ph = 2'd2; pc = tc - plen(u, 1);
      end else begin
        ph = 2'd3; pc = tc - plen(u, 1) - plen(u, 2);
      end
    end
    return {m_busy[u], ph, ph == 2'd1, ph == 2'd2, ph == 2'd3, 9'(pc), 9'(tc), 8'(ti),
            m_td[u], m_jd[u], m_end[u]};
  endfunction

  function automatic logic [34:0] act_vec(int u);
    return {busy_o[u], phase_o[u], len_o[u], fen_o[u], den_o[u], pc_o[u], tc_o[u], ti_o[u],
            td_o[u], jd_o[u], end_o[u]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) chk($sformatf("model_u%0d", u), act_vec(u), exp_vec(u));
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic start_job(input int u, input logic [7:0] n);
    start_v[u] = 1'b1; nt_v[u] = n;
    tick;
    start_v[u] = 1'b0;
  endtask

  int         nbusy, maxtc, ntd, njd, jd_at;
  logic [1:0] ph127, ph128, ph256;
  logic [35:0] phseq, tiseq;
  logic [29:0] tdmask, jdmask;
  logic        any_busy, any_td, any_jd, found;

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      start_v[u] = 1'b0; abort_v[u] = 1'b0; nt_v[u] = 8'd0;
    end
    tick; tick;
    chk("rst_busy", busy_o[0], 0);
    chk("rst_phase", phase_o[0], 0);
    chk("rst_counts", {pc_o[0], tc_o[0], ti_o[0]}, 0);
    chk("rst_flags", {td_o[0], jd_o[0], end_o[0]}, 0);
    rst = 1'b0;
    tick;

    // Default lengths, one tile; num_tiles changes after accept must be ignored.
    start_job(0, 8'd1);
    nt_v[0] = 8'd5;
    nbusy = 0; maxtc = 0; ntd = 0; njd = 0; jd_at = -1;
    ph127 = 0; ph128 = 0; ph256 = 0;
    for (int n = 0; n < 400; n++) begin
      if (busy_o[0]) nbusy++;
      if (int'(tc_o[0]) > maxtc) maxtc = int'(tc_o[0]);
      if (td_o[0]) ntd++;
      if (jd_o[0]) begin njd++; jd_at = n; end
      if (n == 127) ph127 = phase_o[0];
      if (n == 128) ph128 = phase_o[0];
      if (n == 256) ph256 = phase_o[0];
      tick;
    end
    chk("A_busy_cycles", nbusy, 384);
    chk("A_max_tile_count", maxtc, 383);
    chk("A_tile_done_pulses", ntd, 1);
    chk("A_job_done_pulses", njd, 1);
    chk("A_job_done_cycle", jd_at, 384);
    chk("A_phase_127", ph127, 1);
    chk("A_phase_128", ph128, 2);
    chk("A_phase_256", ph256, 3);
    chk("A_end_sticky", end_o[0], 1);

    // Short phases, three tiles, with a start/num_tiles change while busy.
    start_job(1, 8'd3);
    phseq = '0; tiseq = '0; tdmask = '0; jdmask = '0; nbusy = 0;
    for (int n = 0; n < 30; n++) begin
      if (n < 18) begin
        phseq = {phseq[33:0], phase_o[1]};
        tiseq = {tiseq[33:0], ti_o[1][1:0]};
      end
      tdmask[n] = td_o[1];
      jdmask[n] = jd_o[1];
      if (busy_o[1]) nbusy++;
      if (n == 3) begin start_v[1] = 1'b1; nt_v[1] = 8'd7; end
      if (n == 5) start_v[1] = 1'b0;
      tick;
    end
    chk("B_phase_seq", phseq, 36'h5AB5AB5AB);
    chk("B_tile_idx_seq", tiseq, 36'h000555AAA);
    chk("B_tile_done_cycles", tdmask, 30'h00041040);
    chk("B_job_done_cycles", jdmask, 30'h00040000);
    chk("B_busy_cycles", nbusy, 18);

    // num_tiles==0: start ignored, end_signal untouched.
    start_v[1] = 1'b1; nt_v[1] = 8'd0;
    any_busy = 0; any_td = 0; any_jd = 0;
    for (int n = 0; n < 3; n++) begin
      tick;
      any_busy |= busy_o[1]; any_td |= td_o[1]; any_jd |= jd_o[1];
    end
    start_v[1] = 1'b0;
    chk("C_busy", any_busy, 0);
    chk("C_pulses", {any_td, any_jd}, 0);
    chk("C_end_kept", end_o[1], 1);

    // Abort at FEED phase_count 5 of tile 1.
    start_job(0, 8'd2);
    found = 0;
    for (int n = 0; n < 1000 && !found; n++) begin
      if (ti_o[0] == 8'd1 && phase_o[0] == 2'd2 && pc_o[0] == 9'd5) found = 1;
      else tick;
    end
    chk("D1_reached_feed5", found, 1);
    abort_v[0] = 1'b1;
    tick;
    abort_v[0] = 1'b0;
    chk("D1_idle", {busy_o[0], phase_o[0]}, 0);
    chk("D1_counts", {pc_o[0], tc_o[0], ti_o[0]}, 0);
    chk("D1_flags", {td_o[0], jd_o[0], end_o[0]}, 0);

    // Abort coincident with the last DRAIN cycle.
    start_job(1, 8'd1);
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (phase_o[1] == 2'd3) found = 1;
      else tick;
    end
    chk("D2_reached_drain", found, 1);
    abort_v[1] = 1'b1;
    tick;
    abort_v[1] = 1'b0;
    chk("D2_idle", {busy_o[1], phase_o[1], tc_o[1]}, 0);
    chk("D2_flags", {td_o[1], jd_o[1], end_o[1]}, 0);
    any_jd = 0;
    for (int n = 0; n < 4; n++) begin tick; any_jd |= jd_o[1]; end
    chk("D2_no_job_done", any_jd, 0);

    // Abort in IDLE with start: clears end_signal, start ignored.
    start_job(1, 8'd1);
    repeat (8) tick;
    chk("D3_end_before", end_o[1], 1);
    abort_v[1] = 1'b1; start_v[1] = 1'b1;
    tick;
    abort_v[1] = 1'b0; start_v[1] = 1'b0;
    chk("D3_end_cleared", end_o[1], 0);
    chk("D3_not_started", busy_o[1], 0);

    // Async reset mid-DRAIN, then a fresh full job.
    start_job(0, 8'd1);
    found = 0;
    for (int n = 0; n < 400 && !found; n++) begin
      if (phase_o[0] == 2'd3 && pc_o[0] == 9'd10) found = 1;
      else tick;
    end
    chk("E_reached_drain", found, 1);
    #2 rst = 1'b1;
    #1;
    chk("E_async_idle", {busy_o[0], phase_o[0], den_o[0]}, 0);
    chk("E_async_counts", {pc_o[0], tc_o[0], ti_o[0]}, 0);
    tick;
    rst = 1'b0;
    tick;
    start_job(0, 8'd1);
    chk("E_fresh_first", {phase_o[0], tc_o[0], ti_o[0]}, {2'd1, 9'd0, 8'd0});
    nbusy = 0; njd = 0;
    for (int n = 0; n < 400; n++) begin
      if (busy_o[0]) nbusy++;
      if (jd_o[0]) njd++;
      tick;
    end
    chk("E_busy_cycles", nbusy, 384);
    chk("E_job_done_pulses", njd, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
